hopfield_phase_controller: RTL and testbench
============================================

// Module: hopfield_phase_controller
// PURPOSE
//  Sequences the 7-neuron Hopfield network through its learn and recall phases.
//  - LEARN: drives learning_enable and pattern_input for a fixed window, so the
//    Hebbian block stores the pattern.
//  - RECALL: applies a short cue, then free-runs the network with learning off.
//    It counts spikes per neuron and thresholds the counts into a 7-bit
//    recalled pattern.
//  Sits between the host command interface and hopfield_network.
// PARAMETERS
//  N             7     neuron count (width of spikes/result)
//  LEARN_CYCLES  256   cycles learning_enable is held high per learn command (>=1)
//  CUE_CYCLES    16    cue cycles at the start of a recall command (>=1)
//  RECALL_CYCLES 1024  free-run spike-counting window (>=1)
//  CNT_W         8     per-neuron spike counter width (saturating)
//  THRESH        4     minimum spike count for a result bit to be set
// PORTS
//  clk             in   1      system clock
//  reset_n         in   1      asynchronous active-low reset
//  cmd_valid       in   1      host command valid
//  cmd_ready       out  1      controller can accept a command (high only in IDLE)
//  cmd_recall      in   1      0 = learn command, 1 = recall command
//  cmd_pattern     in   4      pattern to learn, or cue for recall
//  abort           in   1      synchronous abort of the running command
//  spikes          in   N      spike outputs from hopfield_network
//  learning_enable out  1      to hopfield_network
//  pattern_input   out  4      to hopfield_network
//  busy            out  1      high in every state except IDLE
//  done            out  1      one-cycle completion pulse
//  result          out  N      recalled pattern, held until the next recall completes
// BEHAVIOUR
//  Reset (asynchronous, active-low): state IDLE; timer and counters 0.
//  - Outputs: learning_enable=0, pattern_input=0, busy=0, done=0, result=0.
//  States: IDLE, LEARN, CUE, RECALL, DONE. All outputs are registered.
//  Command handshake:
//  - cmd_ready = (state==IDLE). A command is accepted on a cycle where
//    cmd_valid & cmd_ready are both high.
//  - cmd_recall and cmd_pattern are captured on the accept cycle.
//  - cmd_valid outside IDLE is ignored; there is no queueing.
//  Learn command, accepted in cycle 0:
//  - Cycles 1..LEARN_CYCLES: state LEARN, learning_enable=1, pattern_input=captured.
//  - Next cycle: state DONE, done=1, learning_enable=0, pattern_input=0.
//  - Following cycle: back to IDLE. result is unchanged.
//  Recall command, accepted in cycle 0:
//  - CUE, cycles 1..CUE_CYCLES: learning_enable=1, pattern_input=cue.
//  - RECALL, the next RECALL_CYCLES cycles: learning_enable=0, pattern_input=0.
//    All N spike counters are zero on the first RECALL cycle.
//  - In each RECALL cycle, counter[i] += spikes[i]. Counters saturate at
//    2^CNT_W-1 and never wrap. Spikes during CUE, DONE and IDLE are not counted.
//  - DONE: result[i] = (counter[i] >= THRESH), with the comparison unsigned.
//    result updates on the same edge that raises done. done=1 for one cycle,
//    then IDLE.
//  Timer: a single down-counter.
//  - Width is $clog2(max(LEARN,CUE,RECALL)+1).
//  - It is loaded on every state entry, and the phase ends when it reaches 1.
//  Abort:
//  - In LEARN, CUE or RECALL: next state is IDLE. learning_enable and
//    pattern_input go low on the next edge.
//  - No done pulse is issued, and result keeps its previous value.
//  - Abort in IDLE or DONE has no effect; DONE still pulses.
//  Abort has priority over phase completion on the same cycle.
//  Back-to-back: cmd_ready is high again on the cycle after DONE. The earliest
//  next accept is therefore 2 cycles after the last active-phase cycle.
//  Reset asserted mid-command returns all state and outputs to reset values
//  immediately. No done is issued.
// TESTING
//  1. Learn 4'b1011, LEARN_CYCLES=256: learning_enable high for exactly 256
//     cycles with pattern_input=1011 -> one done pulse, result stays 0,
//     cmd_ready returns high.
//  2. Recall with forced spikes=7'b0000101 every RECALL cycle (1024 cycles)
//     -> counters 0 and 2 saturate at 255, result=7'b0000101.
//  3. Recall where neuron 3 spikes 3 times and neuron 4 spikes 4 times in
//     the window, with spikes also driven during CUE -> result bit3=0,
//     bit4=1; CUE spikes are not counted.
//  4. Abort at RECALL cycle 100 -> IDLE next cycle, no done, result keeps its
//     prior value, and a new learn is accepted.
//  5. cmd_valid held high throughout -> exactly one accept per
//     IDLE visit; commands during busy are dropped and there is no done
//     without an accept.
//  6. reset_n pulsed low mid-LEARN -> all outputs 0 asynchronously;
//     after release, a recall runs normally.

Source files
------------

// File: rtl/hopfield_phase_controller.sv
// hopfield_phase_controller: sequences the Hopfield network through learn and recall phases
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           host command handshake (ready only in IDLE)
//   cmd_recall, cmd_pattern       command type (1 = recall) and pattern or cue
//   abort                         synchronous abort of the running command
//   spikes                        per-neuron spikes from the network
//   learning_enable,pattern_input drive to the network
//   busy, done, result            status, completion pulse, recalled pattern
module hopfield_phase_controller #(
    parameter int N             = 7,
    parameter int LEARN_CYCLES  = 256,
    parameter int CUE_CYCLES    = 16,
    parameter int RECALL_CYCLES = 1024,
    parameter int CNT_W         = 8,
    parameter int unsigned THRESH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_recall,
    input  logic [3:0]   cmd_pattern,
    input  logic         abort,
    input  logic [N-1:0] spikes,
    output logic         learning_enable,
    output logic [3:0]   pattern_input,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int MLC  = LEARN_CYCLES > CUE_CYCLES ? LEARN_CYCLES : CUE_CYCLES;
    localparam int MAXC = MLC > RECALL_CYCLES ? MLC : RECALL_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, LEARN, CUE, RECALL, DONE} state_t;
    state_t                     state, nxt;
    logic [TW-1:0]              tmr, tmr_nxt;
    logic [3:0]                 pat, pat_nxt;
    logic [N-1:0][CNT_W-1:0]    cnt, cnt_nxt;
    logic [N-1:0]               res_nxt;
    logic                       act;
    assign cmd_ready = (state == IDLE);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_valid ? (cmd_recall ? CUE : LEARN) : IDLE;
            LEARN:   nxt = abort ? IDLE : (tmr == TW'(1) ? DONE : LEARN);
            CUE:     nxt = abort ? IDLE : (tmr == TW'(1) ? RECALL : CUE);
            RECALL:  nxt = abort ? IDLE : (tmr == TW'(1) ? DONE : RECALL);
            default: nxt = IDLE;
        endcase
        // timer reloads on every state change, otherwise counts down inside active phases
        tmr_nxt = (nxt != state) ? (nxt == LEARN  ? TW'(LEARN_CYCLES) :
                                    nxt == CUE    ? TW'(CUE_CYCLES) :
                                    nxt == RECALL ? TW'(RECALL_CYCLES) : '0)
                                 : ((state == IDLE || state == DONE) ? '0 : tmr - 1'b1);
        pat_nxt = (state == IDLE) ? cmd_pattern : pat;
        act     = (nxt == LEARN) || (nxt == CUE);
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = (spikes[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
            res_nxt[i] = 32'(cnt_nxt[i]) >= THRESH;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            tmr             <= '0;
            pat             <= '0;
            cnt             <= '0;
            learning_enable <= 1'b0;
            pattern_input   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            result          <= '0;
        end else begin
            state           <= nxt;
            tmr             <= tmr_nxt;
            pat             <= pat_nxt;
            learning_enable <= act;
            pattern_input   <= act ? pat_nxt : '0;
            busy            <= (nxt != IDLE);
            done            <= (nxt == DONE);
            // counters only live inside RECALL, so they are zero on its first cycle
            cnt             <= (state == RECALL) ? cnt_nxt : '0;
            // result includes the spikes of the final RECALL cycle
            if (state == RECALL && nxt == DONE) result <= res_nxt;
        end
    end
endmodule

// File: tb/tb_hopfield_phase_controller.sv
// tb_hopfield_phase_controller: directed self-checking bench for hopfield_phase_controller
module tb_hopfield_phase_controller;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_recall = 1'b0;
    logic [3:0] cmd_pattern = '0;
    logic       abort = 1'b0;
    logic [6:0] spikes = '0;
    logic       learning_enable;
    logic [3:0] pattern_input;
    logic       busy;
    logic       done;
    logic [6:0] result;
    int checks = 0;
    int errors = 0;
    int le_cnt, done_cnt, rdy_cnt, bad, done_at;
    hopfield_phase_controller dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_recall(cmd_recall), .cmd_pattern(cmd_pattern), .abort(abort), .spikes(spikes),
        .learning_enable(learning_enable), .pattern_input(pattern_input),
        .busy(busy), .done(done), .result(result)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic logic [6:0] spk(input int mode, input int c);
        case (mode)
            1: return 7'b0000101;
            2: begin
                if (c >= 1 && c <= 16) return 7'b0011000;
                if (c == 17 || c == 500 || c == 501 || c == 1040) return 7'b0010000;
                if ((c >= 100 && c <= 102) || c == 1041) return 7'b0001000;
                return 7'b0;
            end
            3: return 7'b1111111;
            4: return 7'b1000001;
            default: return 7'b0;
        endcase
    endfunction
    // iteration c samples cycle c (cycle 0 is the accept cycle) and drives inputs for it
    task automatic run(input int n, input int abort_at, input int mode, input logic recall,
                       input logic [3:0] pat, input logic hold);
        le_cnt = 0; done_cnt = 0; rdy_cnt = 0; bad = 0; done_at = -1;
        cmd_recall = recall;
        cmd_pattern = pat;
        for (int c = 0; c < n; c++) begin
            le_cnt += int'(learning_enable);
            done_cnt += int'(done);
            rdy_cnt += int'(cmd_ready);
            if (done) done_at = c;
            if (learning_enable && pattern_input !== pat) bad++;
            if (!learning_enable && pattern_input !== 4'b0) bad++;
            if (cmd_ready === busy) bad++;
            cmd_valid = (c == 0) || hold;
            abort = (c == abort_at);
            spikes = spk(mode, c);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        spikes = '0;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_le", learning_enable, 0);
        chk("rst_pi", pattern_input, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        // learn 1011
        run(300, -1, 0, 1'b0, 4'b1011, 1'b0);
        chk("learn_le_cycles", le_cnt, 256);
        chk("learn_pi_bad", bad, 0);
        chk("learn_done_cnt", done_cnt, 1);
        chk("learn_done_at", done_at, 257);
        chk("learn_ready_cnt", rdy_cnt, 43);
        chk("learn_result", result, 0);
        // recall with neurons 0 and 2 spiking every cycle
        run(1060, -1, 1, 1'b1, 4'b0110, 1'b0);
        chk("rc1_le_cycles", le_cnt, 16);
        chk("rc1_bad", bad, 0);
        chk("rc1_done_cnt", done_cnt, 1);
        chk("rc1_done_at", done_at, 1041);
        chk("rc1_ready_cnt", rdy_cnt, 19);
        chk("rc1_result", result, 7'b0000101);
        // recall with 3 and 4 window spikes, cue spikes and a DONE-cycle spike ignored
        run(1060, -1, 2, 1'b1, 4'b1001, 1'b0);
        chk("rc2_done_at", done_at, 1041);
        chk("rc2_result", result, 7'b0010000);
        // abort at RECALL cycle 100
        run(130, 116, 3, 1'b1, 4'b0001, 1'b0);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_ready_cnt", rdy_cnt, 14);
        chk("abort_bad", bad, 0);
        chk("abort_result", result, 7'b0010000);
        // learn aborted on its final cycle: abort wins over completion
        run(300, 256, 0, 1'b0, 4'b0110, 1'b0);
        chk("abort_last_le", le_cnt, 256);
        chk("abort_last_done", done_cnt, 0);
        chk("abort_last_ready", rdy_cnt, 44);
        chk("abort_last_result", result, 7'b0010000);
        // cmd_valid held high across several IDLE visits
        run(600, -1, 0, 1'b0, 4'b1100, 1'b1);
        chk("hold_accepts", rdy_cnt, 3);
        chk("hold_dones", done_cnt, 2);
        chk("hold_le", le_cnt, 595);
        chk("hold_bad", bad, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("hold_cleanup_busy", busy, 0);
        // asynchronous reset in the middle of a learn
        run(50, -1, 0, 1'b0, 4'b1111, 1'b0);
        chk("mid_learn_le", learning_enable, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_le", learning_enable, 0);
        chk("arst_pi", pattern_input, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(1060, -1, 4, 1'b1, 4'b0011, 1'b0);
        chk("post_rst_le", le_cnt, 16);
        chk("post_rst_done_at", done_at, 1041);
        chk("post_rst_result", result, 7'b1000001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
